// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizes, types and well-known register indices for the register file
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Flattened storage view handed to the read muxes
    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

    // Architectural register indices used by surrounding blocks
    localparam reg_addr_t REG_SP = 4'd13;
    localparam reg_addr_t REG_LR = 4'd14;
    localparam reg_addr_t REG_PC = 4'd15;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - combinational NUM_REGS:1 read mux over the flattened register array
module reg_file_rd_port
    import reg_file_pkg::*;
(
    input  reg_array_t regs_i,
    input  reg_addr_t  addr_i,
    output reg_data_t  data_o
);

    // Pure mux: an address change shows up without any clock
    always_comb begin
        data_o = regs_i[addr_i];
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x32 register file, one synchronous write port, three combinational read ports
module reg_file
    import reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      w_en,
    input  reg_addr_t w_addr,
    input  reg_data_t w_data,
    input  reg_addr_t A_addr,
    input  reg_addr_t B_addr,
    input  reg_addr_t shift_addr,
    output reg_data_t A_data,
    output reg_data_t B_data,
    output reg_data_t shift_data
);

    reg_array_t regs_q;
    reg_array_t regs_d;

    // Next-state: only the addressed register takes the write data; no register is hardwired
    always_comb begin
        regs_d = regs_q;
        if (w_en) begin
            regs_d[w_addr] = w_data;
        end
    end

    // Storage: asynchronous clear wins over any write in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports read the stored array directly, so there is no write-to-read bypass
    reg_file_rd_port u_rd_a (
        .regs_i (regs_q),
        .addr_i (A_addr),
        .data_o (A_data)
    );

    reg_file_rd_port u_rd_b (
        .regs_i (regs_q),
        .addr_i (B_addr),
        .data_o (B_data)
    );

    reg_file_rd_port u_rd_shift (
        .regs_i (regs_q),
        .addr_i (shift_addr),
        .data_o (shift_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - vector-table and scoreboard bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      w_en;
    reg_addr_t w_addr;
    reg_data_t w_data;
    reg_addr_t A_addr;
    reg_addr_t B_addr;
    reg_addr_t shift_addr;
    reg_data_t A_data;
    reg_data_t B_data;
    reg_data_t shift_data;

    reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .A_addr     (A_addr),
        .B_addr     (B_addr),
        .shift_addr (shift_addr),
        .A_data     (A_data),
        .B_data     (B_data),
        .shift_data (shift_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      we;
        reg_addr_t wa;
        reg_data_t wd;
        reg_addr_t a;
        reg_addr_t b;
        reg_addr_t s;
        logic      tick;
        reg_data_t ea;
        reg_data_t eb;
        reg_data_t es;
    } vec_t;

    typedef struct {
        int        idx;
        reg_data_t ea;
        reg_data_t eb;
        reg_data_t es;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string name, input int idx, input reg_data_t got, input reg_data_t exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic we, input reg_addr_t wa, input reg_data_t wd,
                       input reg_addr_t a, input reg_addr_t b, input reg_addr_t s,
                       input logic tick, input reg_data_t ea, input reg_data_t eb, input reg_data_t es);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.a = a; v.b = b; v.s = s; v.tick = tick;
        v.ea = ea; v.eb = eb; v.es = es;
        vecs.push_back(v);
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        w_en = 1'b0; w_addr = '0; w_data = '0;
        A_addr = '0; B_addr = '0; shift_addr = '0;

        // Reset state while held
        tick_edge();
        tick_edge();
        A_addr = 4'd0; B_addr = 4'd7; shift_addr = 4'd15;
        #1;
        check("rst_hold_a", 0, A_data, 32'h0);
        check("rst_hold_b", 0, B_data, 32'h0);
        check("rst_hold_s", 0, shift_data, 32'h0);
        rst_n = 1'b1;

        // Write R5 then clear asynchronously
        w_en = 1'b1; w_addr = 4'd5; w_data = 32'hDEADBEEF; A_addr = 4'd5;
        tick_edge();
        check("r5_written", 5, A_data, 32'hDEADBEEF);
        w_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 5, A_data, 32'h0);

        // Write attempted during reset must be ignored
        w_en = 1'b1; w_addr = 4'd5; w_data = 32'h1234_5678;
        tick_edge();
        check("rst_priority", 5, A_data, 32'h0);
        w_en = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            A_addr = reg_addr_t'(i);
            #1;
            check("post_rst", i, A_data, 32'h0);
        end

        // Vector table
        for (int i = 0; i < NUM_REGS; i++)
            add(1'b1, reg_addr_t'(i), reg_data_t'(i), reg_addr_t'(i), reg_addr_t'(i), reg_addr_t'(i),
                1'b1, reg_data_t'(i), reg_data_t'(i), reg_data_t'(i));
        for (int i = 0; i < 14; i++)
            add(1'b0, 4'd0, 32'hFFFF_FFFF, reg_addr_t'(i), reg_addr_t'(i + 1), reg_addr_t'(i + 2),
                1'b0, reg_data_t'(i), reg_data_t'(i + 1), reg_data_t'(i + 2));
        add(1'b0, 4'd3, 32'hFFFF_FFFF, 4'd3, 4'd3, 4'd3, 1'b1, 32'd3, 32'd3, 32'd3);
        add(1'b1, 4'd7, 32'hA5A5_A5A5, 4'd7, 4'd7, 4'd7, 1'b0, 32'd7, 32'd7, 32'd7);
        add(1'b1, 4'd7, 32'hA5A5_A5A5, 4'd7, 4'd7, 4'd7, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        add(1'b1, 4'd2, 32'h11, 4'd2, 4'd1, 4'd3, 1'b1, 32'h11, 32'd1, 32'd3);
        add(1'b1, 4'd2, 32'h22, 4'd2, 4'd1, 4'd3, 1'b1, 32'h22, 32'd1, 32'd3);
        add(1'b1, 4'd0, 32'h1234_5678, 4'd0, 4'd15, 4'd2, 1'b1, 32'h1234_5678, 32'd15, 32'h22);
        add(1'b1, 4'd15, 32'hCAFE_F00D, 4'd15, 4'd0, 4'd15, 1'b1, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D);
        add(1'b0, 4'd15, 32'h0, 4'd6, 4'd13, 4'd14, 1'b1, 32'd6, 32'd13, 32'd14);

        foreach (vecs[k]) begin
            w_en = vecs[k].we; w_addr = vecs[k].wa; w_data = vecs[k].wd;
            A_addr = vecs[k].a; B_addr = vecs[k].b; shift_addr = vecs[k].s;
            e.idx = k; e.ea = vecs[k].ea; e.eb = vecs[k].eb; e.es = vecs[k].es;
            sb.push_back(e);
            if (vecs[k].tick) tick_edge();
            else #1;
            if (sb.size() == 0) begin
                check("sb_underflow", k, 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("vec_a", e.idx, A_data, e.ea);
                check("vec_b", e.idx, B_data, e.eb);
                check("vec_s", e.idx, shift_data, e.es);
            end
        end
        w_en = 1'b0;
        check("sb_drained", sb.size(), 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
General-purpose register file for the ARM32 CPU datapath. It holds 16 × 32-bit registers, with one synchronous write port and three asynchronous read ports: A operand, B operand, and shift-amount register (Rs). It sits between decode and the ALU/shifter. R15 is stored as an ordinary register; any PC special-casing is done outside this block.

Parameters:
DATA_W, 32, width of each register and of the data ports
ADDR_W, 4, register address width
NUM_REGS, 16, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock; all writes occur on the rising edge
rst_n  input  1  asynchronous active-low reset
w_en  input  1  write enable
w_addr  input  ADDR_W  write register index
w_data  input  DATA_W  write data
A_addr  input  ADDR_W  read port A index
B_addr  input  ADDR_W  read port B index
shift_addr  input  ADDR_W  read port shift index
A_data  output  DATA_W  contents of register A_addr
B_data  output  DATA_W  contents of register B_addr
shift_data  output  DATA_W  contents of register shift_addr

Behaviour:
- Reset: rst_n low clears all 16 registers to 32'h0 immediately, without waiting for clk. All read outputs therefore show 0 while reset is held. Reset has priority over a write in the same cycle.
- Write: on posedge clk with rst_n high and w_en=1, regs[w_addr] <= w_data. With w_en=0, no register changes.
- Read: all three ports are purely combinational, i.e. X_data = regs[X_addr].
  - An address change is reflected in the same delta cycle, with no clock required.
  - A written value is visible on every port addressing that register immediately after the write edge.
- Same-cycle read-during-write: no bypass. Before the edge a port returns the old value; after the edge it returns the new value.
- The three ports are independent. Any or all may address the same register, including the one being written, and each must return identical data.
- No register is hardwired. R0 and R15 are writable and readable like the others.
- w_addr is always in range because ADDR_W=4 covers all 16 registers.
- Every output must be a known value after reset; no X may propagate from uninitialised storage.

Decomposition:
- Shared package reg_file_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS
  - typedef reg_addr_t (logic [ADDR_W-1:0])
  - typedef reg_data_t (logic [DATA_W-1:0])
  - named constants REG_SP=13, REG_LR=14, REG_PC=15 for use by other blocks
- Storage plus write logic lives in reg_file. One natural sub-module, reg_file_rd_port, is a combinational NUM_REGS:1 read mux. It takes the flattened register array and an address and returns the data. It is instantiated three times (A, B, shift).

Test Plan:
- Reset: assert rst_n=0 after writing 0xDEADBEEF to R5, with no clk edge → A_data=0 when A_addr=5. Release reset and read all 16 registers → every register reads 0.
- Write/readback sweep: for i=0..15, w_en=1, w_addr=i, w_data=i, A_addr=i, one clk edge → A_data=i immediately after each edge (R15 reads 15).
- Triple-port read: w_en=0; for i=0..13 set A_addr=i, B_addr=i+1, shift_addr=i+2, no clock → A_data=i, B_data=i+1, shift_data=i+2.
- Write disable: w_en=0, w_addr=3, w_data=0xFFFFFFFF, clock edge → R3 still reads 3 on all ports.
- Read-during-write: R7=7; set w_addr=7, w_data=0xA5A5A5A5, w_en=1, A_addr=B_addr=shift_addr=7 → all ports read 7 before the edge and 0xA5A5A5A5 after it.
- Back-to-back writes: write R2=0x11 then R2=0x22 on consecutive edges → R2 reads 0x22; R1 and R3 unchanged.
